// File: rtl/prio_req_encoder.sv
`default_nettype none
// ============================================================================
// Module  : prio_req_encoder
// Brief   : Registered N-to-log2(N) priority encoder that captures requests into
//           a pending vector and drains one index per valid/ready transfer.
//           Define ROUND_ROBIN_EN for rotating priority (default: highest index).
// Revision: 1.0 - initial release
// ============================================================================
module prio_req_encoder #(
  parameter int N        = 16,
  parameter int EDGE_DET = 0,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [N-1:0]     w,
  output logic [IDX_W-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             busy,
  output logic             ovf
);

  logic [N-1:0]     w_q;
  logic [N-1:0]     pend_q;
  logic [N-1:0]     pend_d;
  logic [N-1:0]     rise;
  logic [N-1:0]     cap;
  logic [N-1:0]     load_mask;
  logic [IDX_W-1:0] y_q;
  logic [IDX_W-1:0] y_d;
  logic             y_valid_q;
  logic             y_valid_d;
  logic [IDX_W-1:0] grant;
  logic             stage_free;
  logic             load;

  function automatic logic [IDX_W-1:0] f_highest(input logic [N-1:0] v);
    f_highest = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) f_highest = IDX_W'(i);
    end
  endfunction

  assign rise       = w & ~w_q;
  assign cap        = en ? ((EDGE_DET != 0) ? rise : w) : '0;
  assign stage_free = ~y_valid_q | y_ready;
  assign load       = stage_free & (|pend_q);

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q;
  logic [N-1:0]     pend_rot;
  logic [IDX_W:0]   rot_sum;
  logic [IDX_W-1:0] rot_idx;
  logic [IDX_W:0]   grant_sum;

  // Bit j of pend_rot is pend[(rr_ptr + j) mod N], so the top bit is rr_ptr-1.
  always_comb begin
    pend_rot = '0;
    rot_sum  = '0;
    for (int j = 0; j < N; j++) begin
      rot_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(j);
      if (rot_sum >= (IDX_W+1)'(N)) rot_sum = rot_sum - (IDX_W+1)'(N);
      pend_rot[j] = pend_q[rot_sum[IDX_W-1:0]];
    end
  end

  assign rot_idx = f_highest(pend_rot);

  always_comb begin
    grant_sum = {1'b0, rr_ptr_q} + {1'b0, rot_idx};
    if (grant_sum >= (IDX_W+1)'(N)) grant_sum = grant_sum - (IDX_W+1)'(N);
    grant = grant_sum[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (clr) begin
      rr_ptr_q <= '0;
    end else if (load) begin
      rr_ptr_q <= grant;
    end
  end
`else
  assign grant = f_highest(pend_q);
`endif

  always_comb begin
    load_mask = '0;
    if (load) load_mask[grant] = 1'b1;
  end

  // A bit re-captured on its own load edge stays pending (set wins over clear).
  always_comb begin
    pend_d    = (pend_q & ~load_mask) | cap;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    if (clr) begin
      pend_d    = '0;
      y_valid_d = 1'b0;
    end else if (load) begin
      y_d       = grant;
      y_valid_d = 1'b1;
    end else if (stage_free) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= '0;
      pend_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      w_q       <= w;
      pend_q    <= pend_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  generate
    if (EDGE_DET != 0) begin : g_ovf
      logic [N-1:0] ovf_hit;
      logic         ovf_q;
      logic         ovf_d;

      assign ovf_hit = cap & pend_q & ~load_mask;
      assign ovf_d   = clr ? 1'b0 : (ovf_q | (|ovf_hit));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end

      assign ovf = ovf_q;
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (|pend_q) | y_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_req_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_prio_req_encoder
// Brief   : Self-checking bench: level-capture and edge-capture instances,
//           scoreboard of expected grant indices plus directed corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prio_req_encoder;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b1;
  logic          clr   = 1'b0;
  logic          rdy   = 1'b0;
  logic [N-1:0]  w0    = '0;
  logic [N-1:0]  w1    = '0;
  logic [IW-1:0] y0, y1;
  logic          v0, v1, busy0, busy1, ovf0, ovf1;

  int n_chk   = 0;
  int n_fail  = 0;
  int got_cnt = 0;
  bit mon_en  = 1'b1;
  int exp_q[$];

  typedef struct {
    logic [N-1:0] w;
    logic         en;
    int           cnt;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  prio_req_encoder #(.N(N), .EDGE_DET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .w(w0),
    .y(y0), .y_valid(v0), .y_ready(rdy), .busy(busy0), .ovf(ovf0)
  );

  prio_req_encoder #(.N(N), .EDGE_DET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .w(w1),
    .y(y1), .y_valid(v1), .y_ready(rdy), .busy(busy1), .ovf(ovf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Scoreboard for the level-capture instance: one pop per accepted transfer.
  always @(negedge clk) begin
    if (mon_en && v0 && rdy) begin
      got_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: actual y=%0d required no transfer at t=%0t", y0, $time);
      end else begin
        check("sb_y", {28'd0, y0}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{w: 16'h0091, en: 1'b1, cnt: 3};
    vecs[1] = '{w: 16'hFFFF, en: 1'b1, cnt: 16};
    vecs[2] = '{w: 16'h8000, en: 1'b1, cnt: 1};
    vecs[3] = '{w: 16'h0001, en: 1'b1, cnt: 1};
    vecs[4] = '{w: 16'hA5A5, en: 1'b0, cnt: 0};
    vecs[5] = '{w: 16'h5A00, en: 1'b1, cnt: 4};

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", {28'd0, y0}, 0);
    check("rst_valid", {31'd0, v0}, 0);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_ovf1", {31'd0, ovf1}, 0);
    rst_n = 1'b1;
    step();

    // ---------------- single pulse 0x0091, latency ----------------
    rdy = 1'b1;
    w0  = 16'h0091;
    exp_q.push_back(7); exp_q.push_back(4); exp_q.push_back(0);
    step();
    w0 = '0;
    check("lat_not_yet", {31'd0, v0}, 0);
    check("lat_busy", {31'd0, busy0}, 1);
    step();
    check("lat_valid", {31'd0, v0}, 1);
    check("lat_y", {28'd0, y0}, 7);
    repeat (3) step();
    check("burst_done_valid", {31'd0, v0}, 0);
    check("burst_done_busy", {31'd0, busy0}, 0);
    check("burst_drain", exp_q.size(), 0);

    // ---------------- backpressure ----------------
    rdy = 1'b0;
    w0  = 16'h0091;
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(7); exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(9);
`else
    exp_q.push_back(7); exp_q.push_back(9); exp_q.push_back(4); exp_q.push_back(0);
`endif
    step();
    w0 = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_y", {28'd0, y0}, 7);
      check("bp_hold_valid", {31'd0, v0}, 1);
      w0 = (i == 1) ? 16'h0200 : 16'h0000;
      step();
    end
    w0  = '0;
    rdy = 1'b1;
    for (int c = 0; c < 20 && (busy0 || exp_q.size() != 0); c++) step();
    check("bp_idle", {31'd0, busy0}, 0);
    check("bp_drain", exp_q.size(), 0);

    // ---------------- table-driven single-cycle patterns ----------------
    foreach (vecs[k]) begin
      int start;
      pulse_clr();
      start = got_cnt;
      en = vecs[k].en;
      w0 = vecs[k].w;
      if (vecs[k].en) begin
        for (int b = N - 1; b >= 0; b--) begin
          if (vecs[k].w[b]) exp_q.push_back(b);
        end
      end
      step();
      w0 = '0;
      en = 1'b1;
      for (int c = 0; c < 40 && (busy0 || exp_q.size() != 0); c++) step();
      check("tbl_idle", {31'd0, busy0}, 0);
      check("tbl_count", got_cnt - start, vecs[k].cnt);
      check("tbl_drain", exp_q.size(), 0);
    end

    // ---------------- edge capture: re-capture on own load edge ----------------
    pulse_clr();
    rdy = 1'b0;
    w1  = 16'h00A0;
    step();
    w1 = '0;
    step();
    check("edge_first_y", {28'd0, y1}, 7);
    step();
    rdy = 1'b1;
    w1  = 16'h0020;
    check("edge_hold_y", {28'd0, y1}, 7);
    step();
    w1 = '0;
    check("edge_y5_a", {28'd0, y1}, 5);
    check("edge_v5_a", {31'd0, v1}, 1);
    step();
    check("edge_y5_b", {28'd0, y1}, 5);
    check("edge_v5_b", {31'd0, v1}, 1);
    step();
    check("edge_done", {31'd0, v1}, 0);
    check("edge_no_ovf", {31'd0, ovf1}, 0);

    // ---------------- edge capture: overflow on pending bit ----------------
    pulse_clr();
    rdy = 1'b0;
    w1  = 16'h0088;
    step();
    w1 = '0;
    step();
    check("ovf_pre_y", {28'd0, y1}, 7);
    check("ovf_pre", {31'd0, ovf1}, 0);
    w1 = 16'h0008;
    step();
    w1 = '0;
    check("ovf_set", {31'd0, ovf1}, 1);
    step();
    check("ovf_sticky", {31'd0, ovf1}, 1);

    // ---------------- clr flush with everything high ----------------
    w0 = 16'hFFFF;
    step();
    step();
    check("clr_pre_valid", {31'd0, v0}, 1);
    check("lvl_ovf_tied", {31'd0, ovf0}, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    w0  = '0;
    check("clr_valid", {31'd0, v0}, 0);
    check("clr_busy0", {31'd0, busy0}, 0);
    check("clr_busy1", {31'd0, busy1}, 0);
    check("clr_ovf", {31'd0, ovf1}, 0);
    en = 1'b0;
    w0 = 16'hFFFF;
    w1 = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en0_busy0", {31'd0, busy0}, 0);
      check("en0_busy1", {31'd0, busy1}, 0);
    end
    w0 = '0;
    w1 = '0;
    en = 1'b1;
    step();

    // ---------------- held 0x8001: starvation vs rotation ----------------
    pulse_clr();
    rdy = 1'b1;
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(15); exp_q.push_back(0);
`else
    exp_q.push_back(15); exp_q.push_back(15); exp_q.push_back(15);
`endif
    w0 = 16'h8001;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    mon_en = 1'b0;
    w0     = '0;
    check("held_drain", exp_q.size(), 0);
    pulse_clr();
    mon_en = 1'b1;

    // ---------------- async reset mid-transfer ----------------
    rdy = 1'b0;
    w0  = 16'h00F0;
    step();
    w0 = '0;
    step();
    check("arst_pre_valid", {31'd0, v0}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y", {28'd0, y0}, 0);
    check("arst_valid", {31'd0, v0}, 0);
    check("arst_busy", {31'd0, busy0}, 0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_after_busy", {31'd0, busy0}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
